// File: rtl/rv_writeback_nb_pkg.sv
// Shared definitions for the non-blocking writeback stage: load width/sign codes,
// result source selects and the load-queue entry layout.
package rv_writeback_nb_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] RD_SOURCE_ALU      = 2'b00;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'b01;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] fun;
        logic [1:0] off;
    } lq_entry_t;

endpackage

// File: rtl/rv_writeback_nb_load_queue.sv
// In-order circular queue of outstanding loads; also publishes which rd registers
// still have a load in flight so decode can stall on them.
module rv_load_queue
    import rv_writeback_nb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  lq_entry_t                i_push_entry,
    input  logic                     i_pop,
    output lq_entry_t                o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [31:0]              o_pending_mask
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    lq_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     w_idx;
    logic [31:0]       w_mask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (i_pop)  r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Payload storage needs no reset: only slots covered by r_count are ever read.
    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_tail] <= i_push_entry;
    end

    always_comb begin
        w_mask = '0;
        w_idx  = r_head;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) w_mask[r_mem[w_idx].rd] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    assign o_head         = r_mem[r_head];
    assign o_full         = (r_count == CW'(DEPTH));
    assign o_empty        = (r_count == '0);
    assign o_count        = r_count;
    assign o_pending_mask = w_mask;

endmodule

// File: rtl/rv_writeback_nb.sv
// Non-blocking writeback: retires X results to the regfile, tracks outstanding
// loads/stores and writes returning load data in order with zero latency.
module rv_writeback_nb
    import rv_writeback_nb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 4,
    parameter int unsigned ST_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         w_stall_i,
    output logic                         w_stall_req_o,
    input  logic                         x_valid_i,
    input  logic [2:0]                   x_fun_i,
    input  logic                         x_load_i,
    input  logic                         x_store_i,
    input  logic [31:0]                  x_dm_addr_i,
    input  logic [4:0]                   x_rd_i,
    input  logic                         x_rd_write_i,
    input  logic [1:0]                   x_rd_source_i,
    input  logic [31:0]                  x_rd_value_i,
    input  logic [31:0]                  x_shifter_rd_value_i,
    input  logic [31:0]                  x_multiply_rd_value_i,
    input  logic [31:0]                  dm_data_l_i,
    input  logic                         dm_load_done_i,
    input  logic                         dm_store_done_i,
    output logic [4:0]                   rf_rd_o,
    output logic [31:0]                  rf_rd_value_o,
    output logic                         rf_rd_write_o,
    output logic [31:0]                  x_bypass_o,
    output logic [31:0]                  lq_pending_mask_o,
    output logic [$clog2(LQ_DEPTH):0]    lq_count_o,
    output logic [$clog2(ST_DEPTH):0]    st_count_o,
    output logic                         lsu_err_o
);

    localparam int unsigned ST_CW = $clog2(ST_DEPTH) + 1;

    logic [ST_CW-1:0] r_st_count;
    logic [31:0]      r_bypass;
    logic             r_lsu_err;

    lq_entry_t        w_head;
    lq_entry_t        w_push_entry;
    logic             w_lq_full;
    logic             w_lq_empty;
    logic [31:0]      w_mask;
    logic             w_lq_pop;
    logic             w_st_pop;
    logic             w_alu_wr;
    logic             w_retire;
    logic [31:0]      w_src_value;
    logic             w_unused_addr;

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [2:0] fun,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (fun)
            LDST_B:  res = {{24{b[7]}}, b};
            LDST_BU: res = {24'h0, b};
            LDST_H:  res = {{16{h[15]}}, h};
            LDST_HU: res = {16'h0, h};
            LDST_L:  res = d;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    assign w_unused_addr = ^x_dm_addr_i[31:2];

    assign w_lq_pop = dm_load_done_i & ~w_lq_empty;
    assign w_st_pop = dm_store_done_i & (r_st_count != '0);
    assign w_alu_wr = ~x_load_i & ~x_store_i & x_rd_write_i;

    // Last term: regfile write port busy with a load return, or WAW against a pending load.
    assign w_stall_req_o = x_valid_i & (
          (x_load_i  & w_lq_full & ~dm_load_done_i)
        | (x_store_i & (r_st_count == ST_CW'(ST_DEPTH)) & ~dm_store_done_i)
        | (w_alu_wr  & (dm_load_done_i | w_mask[x_rd_i])));

    assign w_retire = x_valid_i & ~w_stall_i & ~w_stall_req_o;

    assign w_push_entry = '{rd: x_rd_i, fun: x_fun_i, off: x_dm_addr_i[1:0]};

    rv_load_queue #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .i_push         (w_retire & x_load_i),
        .i_push_entry   (w_push_entry),
        .i_pop          (w_lq_pop),
        .o_head         (w_head),
        .o_full         (w_lq_full),
        .o_empty        (w_lq_empty),
        .o_count        (lq_count_o),
        .o_pending_mask (w_mask)
    );

    always_comb begin
        case (x_rd_source_i)
            RD_SOURCE_SHIFTER:  w_src_value = x_shifter_rd_value_i;
            RD_SOURCE_MULTIPLY: w_src_value = x_multiply_rd_value_i;
            default:            w_src_value = x_rd_value_i;
        endcase
    end

    // Load returns own the write port and ignore w_stall_i; ALU results only on retire.
    always_comb begin
        rf_rd_o       = 5'd0;
        rf_rd_value_o = 32'h0;
        rf_rd_write_o = 1'b0;
        if (w_lq_pop) begin
            rf_rd_o       = w_head.rd;
            rf_rd_value_o = fmt_load(dm_data_l_i, w_head.fun, w_head.off);
            rf_rd_write_o = (w_head.rd != 5'd0);
        end else if (w_retire & w_alu_wr) begin
            rf_rd_o       = x_rd_i;
            rf_rd_value_o = w_src_value;
            rf_rd_write_o = (x_rd_i != 5'd0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st_count <= '0;
            r_bypass   <= 32'h0;
            r_lsu_err  <= 1'b0;
        end else begin
            case ({w_retire & x_store_i, w_st_pop})
                2'b10:   r_st_count <= r_st_count + ST_CW'(1);
                2'b01:   r_st_count <= r_st_count - ST_CW'(1);
                default: r_st_count <= r_st_count;
            endcase
            if (rf_rd_write_o) r_bypass <= rf_rd_value_o;
            if ((dm_load_done_i & w_lq_empty) | (dm_store_done_i & (r_st_count == '0)))
                r_lsu_err <= 1'b1;
        end
    end

    assign x_bypass_o        = r_bypass;
    assign st_count_o        = r_st_count;
    assign lsu_err_o         = r_lsu_err;
    assign lq_pending_mask_o = w_mask;

endmodule

// File: tb/tb_rv_writeback_nb.sv
// Bench for rv_writeback_nb: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the writeback rules.
module tb_rv_writeback_nb;
    import rv_writeback_nb_pkg::*;

    localparam int unsigned LQ_DEPTH = 4;
    localparam int unsigned ST_DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        w_stall_i;
    logic        w_stall_req_o;
    logic        x_valid_i;
    logic [2:0]  x_fun_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [31:0] x_dm_addr_i;
    logic [4:0]  x_rd_i;
    logic        x_rd_write_i;
    logic [1:0]  x_rd_source_i;
    logic [31:0] x_rd_value_i;
    logic [31:0] x_shifter_rd_value_i;
    logic [31:0] x_multiply_rd_value_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        dm_store_done_i;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic [31:0] x_bypass_o;
    logic [31:0] lq_pending_mask_o;
    logic [2:0]  lq_count_o;
    logic [1:0]  st_count_o;
    logic        lsu_err_o;

    always #5 clk_i = ~clk_i;

    rv_writeback_nb #(.LQ_DEPTH(LQ_DEPTH), .ST_DEPTH(ST_DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .w_stall_i(w_stall_i), .w_stall_req_o(w_stall_req_o),
        .x_valid_i(x_valid_i), .x_fun_i(x_fun_i), .x_load_i(x_load_i), .x_store_i(x_store_i),
        .x_dm_addr_i(x_dm_addr_i), .x_rd_i(x_rd_i), .x_rd_write_i(x_rd_write_i),
        .x_rd_source_i(x_rd_source_i), .x_rd_value_i(x_rd_value_i),
        .x_shifter_rd_value_i(x_shifter_rd_value_i), .x_multiply_rd_value_i(x_multiply_rd_value_i),
        .dm_data_l_i(dm_data_l_i), .dm_load_done_i(dm_load_done_i), .dm_store_done_i(dm_store_done_i),
        .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o), .rf_rd_write_o(rf_rd_write_o),
        .x_bypass_o(x_bypass_o), .lq_pending_mask_o(lq_pending_mask_o), .lq_count_o(lq_count_o),
        .st_count_o(st_count_o), .lsu_err_o(lsu_err_o)
    );

    typedef struct { logic [4:0] rd; logic [2:0] fun; logic [1:0] off; } m_ent_t;

    m_ent_t      m_lq[$];
    int          m_st;
    bit          m_err;
    logic [31:0] m_byp;
    logic [31:0] dut_rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_mask();
        logic [31:0] m = 32'h0;
        foreach (m_lq[i]) if (m_lq[i].rd != 5'd0) m = m | (32'd1 << m_lq[i].rd);
        return m;
    endfunction

    // Load formatting by shift-and-mask arithmetic.
    function automatic logic [31:0] m_fmt(input logic [31:0] d, input logic [2:0] fun,
                                          input logic [1:0] off);
        logic [31:0] bv;
        logic [31:0] hv;
        bv = (d >> (8 * int'(off))) & 32'hFF;
        hv = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
        case (fun)
            LDST_B:  return (bv >= 32'd128)   ? bv - 32'd256     : bv;
            LDST_BU: return bv;
            LDST_H:  return (hv >= 32'd32768) ? hv - 32'h10000   : hv;
            LDST_HU: return hv;
            LDST_L:  return d;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        w_stall_i = 0; x_valid_i = 0; x_fun_i = LDST_L; x_load_i = 0; x_store_i = 0;
        x_dm_addr_i = 0; x_rd_i = 0; x_rd_write_i = 0; x_rd_source_i = RD_SOURCE_ALU;
        x_rd_value_i = 0; x_shifter_rd_value_i = 0; x_multiply_rd_value_i = 0;
        dm_data_l_i = 0; dm_load_done_i = 0; dm_store_done_i = 0;
    endtask

    task automatic model_reset();
        m_lq.delete();
        m_st  = 0;
        m_err = 0;
        m_byp = 32'h0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] fun, input logic [31:0] addr);
        idle();
        x_valid_i = 1; x_load_i = 1; x_rd_i = rd; x_fun_i = fun; x_dm_addr_i = addr;
    endtask

    // One cycle: compare every output against the model, then advance the model.
    task automatic tick();
        logic [31:0] mk, e_val;
        logic [4:0]  e_rd;
        bit          full, stall, retire, pop, spop, e_we;
        @(negedge clk_i);
        mk     = m_mask();
        full   = (m_lq.size() == LQ_DEPTH);
        stall  = x_valid_i && ((x_load_i && full && !dm_load_done_i)
                 || (x_store_i && m_st == ST_DEPTH && !dm_store_done_i)
                 || (!x_load_i && !x_store_i && x_rd_write_i && (dm_load_done_i || mk[x_rd_i])));
        retire = x_valid_i && !w_stall_i && !stall;
        pop    = dm_load_done_i && m_lq.size() > 0;
        spop   = dm_store_done_i && m_st > 0;
        e_we = 0; e_rd = 0; e_val = 0;
        if (pop) begin
            e_rd  = m_lq[0].rd;
            e_val = m_fmt(dm_data_l_i, m_lq[0].fun, m_lq[0].off);
            e_we  = (e_rd != 0);
        end else if (retire && !x_load_i && !x_store_i && x_rd_write_i) begin
            e_rd  = x_rd_i;
            e_val = (x_rd_source_i == RD_SOURCE_SHIFTER)  ? x_shifter_rd_value_i :
                    (x_rd_source_i == RD_SOURCE_MULTIPLY) ? x_multiply_rd_value_i : x_rd_value_i;
            e_we  = (x_rd_i != 0);
        end
        chk("stall_req", 32'(w_stall_req_o), 32'(stall));
        chk("rf_we", 32'(rf_rd_write_o), 32'(e_we));
        if (e_we) begin
            chk("rf_rd", 32'(rf_rd_o), 32'(e_rd));
            chk("rf_val", rf_rd_value_o, e_val);
        end
        chk("lq_count", 32'(lq_count_o), 32'(m_lq.size()));
        chk("st_count", 32'(st_count_o), 32'(m_st));
        chk("mask", lq_pending_mask_o, mk);
        chk("bypass", x_bypass_o, m_byp);
        chk("lsu_err", 32'(lsu_err_o), 32'(m_err));
        if (rf_rd_write_o) dut_rf[rf_rd_o] = rf_rd_value_o;
        if ((dm_load_done_i && m_lq.size() == 0) || (dm_store_done_i && m_st == 0)) m_err = 1;
        if (e_we) m_byp = e_val;
        if (pop) void'(m_lq.pop_front());
        if (retire && x_load_i) m_lq.push_back('{x_rd_i, x_fun_i, x_dm_addr_i[1:0]});
        if (retire && x_store_i) m_st++;
        if (spop) m_st--;
        @(posedge clk_i);
        #1;
    endtask

    logic [2:0] funs [7];

    initial begin
        funs = '{LDST_B, LDST_BU, LDST_H, LDST_HU, LDST_L, LDST_L, 3'b011};
        foreach (dut_rf[i]) dut_rf[i] = 32'h0;
        idle();
        model_reset();
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_lq_count", 32'(lq_count_o), 32'd0);
        chk("rst_st_count", 32'(st_count_o), 32'd0);
        chk("rst_mask", lq_pending_mask_o, 32'h0);
        chk("rst_bypass", x_bypass_o, 32'h0);
        chk("rst_err", 32'(lsu_err_o), 32'd0);
        chk("rst_we", 32'(rf_rd_write_o), 32'd0);
        rst_i = 0;

        // LB sign extension and bypass follow-up
        load(5'd5, LDST_B, 32'h1000_0003);
        tick();
        idle(); dm_load_done_i = 1; dm_data_l_i = 32'h8012_3456;
        #2;
        chk("t1_val", rf_rd_value_o, 32'hFFFF_FF80);
        chk("t1_we", 32'(rf_rd_write_o), 32'd1);
        tick();
        idle();
        #2;
        chk("t1_bypass", x_bypass_o, 32'hFFFF_FF80);
        tick();

        // Fill the load queue, stall the fifth, release it with a done pulse
        for (int i = 1; i <= 4; i++) begin
            load(5'(i), LDST_L, 32'(i * 4));
            tick();
        end
        idle();
        #2;
        chk("t2_count_full", 32'(lq_count_o), 32'd4);
        load(5'd20, LDST_L, 32'h40);
        #2;
        chk("t2_stall", 32'(w_stall_req_o), 32'd1);
        tick();
        dm_load_done_i = 1; dm_data_l_i = 32'h1111_2222;
        #2;
        chk("t2_nostall", 32'(w_stall_req_o), 32'd0);
        tick();
        idle();
        #2;
        chk("t2_count_kept", 32'(lq_count_o), 32'd4);
        tick();
        repeat (4) begin
            idle(); dm_load_done_i = 1; dm_data_l_i = $urandom;
            tick();
        end

        // WAW: ALU write to x7 waits for the pending load to x7
        load(5'd7, LDST_L, 32'h0);
        tick();
        idle(); x_valid_i = 1; x_rd_write_i = 1; x_rd_i = 5'd7; x_rd_value_i = 32'h1234;
        #2;
        chk("t3_stall", 32'(w_stall_req_o), 32'd1);
        tick(); tick();
        dm_load_done_i = 1; dm_data_l_i = 32'hDEAD_0000;
        tick();
        dm_load_done_i = 0;
        tick();
        idle(); tick();
        chk("t3_x7", dut_rf[7], 32'h1234);

        // Done pulse colliding with an ALU retire to x3
        load(5'd9, LDST_L, 32'h0);
        tick();
        idle(); x_valid_i = 1; x_rd_write_i = 1; x_rd_i = 5'd3; x_rd_value_i = 32'h3333;
        dm_load_done_i = 1; dm_data_l_i = 32'h99;
        #2;
        chk("t4_stall", 32'(w_stall_req_o), 32'd1);
        chk("t4_rd", 32'(rf_rd_o), 32'd9);
        tick();
        dm_load_done_i = 0;
        #2;
        chk("t4_release", 32'(w_stall_req_o), 32'd0);
        tick();
        idle(); tick();
        chk("t4_x9", dut_rf[9], 32'h99);
        chk("t4_x3", dut_rf[3], 32'h3333);

        // External stall does not block load completion; store accounting; error flag
        load(5'd10, LDST_L, 32'h0);
        tick();
        idle(); w_stall_i = 1; dm_load_done_i = 1; dm_data_l_i = 32'hA5A5_A5A5;
        #2;
        chk("t5_we_stalled", 32'(rf_rd_write_o), 32'd1);
        tick();
        idle(); x_valid_i = 1; x_store_i = 1; tick();
        dm_store_done_i = 1; tick();
        idle(); dm_store_done_i = 1; tick();
        idle(); dm_store_done_i = 1; tick();
        idle();
        #2;
        chk("t5_err", 32'(lsu_err_o), 32'd1);
        repeat (3) tick();

        // Asynchronous reset with loads outstanding, then a load to x0
        for (int i = 0; i < 3; i++) begin
            load(5'(11 + i), LDST_L, 32'h0);
            tick();
        end
        idle();
        #2;
        rst_i = 1;
        #1;
        chk("t6_lq_count", 32'(lq_count_o), 32'd0);
        chk("t6_mask", lq_pending_mask_o, 32'h0);
        chk("t6_err", 32'(lsu_err_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 0;
        load(5'd0, LDST_L, 32'h0);
        tick();
        idle(); dm_load_done_i = 1; dm_data_l_i = 32'hFFFF_FFFF;
        #2;
        chk("t6_x0_we", 32'(rf_rd_write_o), 32'd0);
        tick();
        idle(); tick();

        // Random traffic
        repeat (3000) begin
            int k;
            idle();
            k = $urandom_range(0, 9);
            w_stall_i             = ($urandom_range(0, 99) < 15);
            x_valid_i             = ($urandom_range(0, 99) < 75);
            x_load_i              = (k < 3);
            x_store_i             = (k >= 3 && k < 5);
            x_rd_write_i          = ($urandom_range(0, 3) != 0);
            x_fun_i               = funs[$urandom_range(0, 6)];
            x_dm_addr_i           = $urandom;
            x_rd_i                = 5'($urandom_range(0, 7));
            x_rd_source_i         = 2'($urandom_range(0, 3));
            x_rd_value_i          = $urandom;
            x_shifter_rd_value_i  = $urandom;
            x_multiply_rd_value_i = $urandom;
            dm_data_l_i           = $urandom;
            dm_load_done_i        = (m_lq.size() > 0) && ($urandom_range(0, 99) < 40);
            dm_store_done_i       = (m_st > 0) && ($urandom_range(0, 99) < 40);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
